// File: rtl/data_mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_sys_pkg
// Shared definitions for the memory subsystem data memory:
//   DMEM_BASE_ADDR : default byte address of word 0 of the data memory window
//   dmem_state_e   : controller state (INIT = zero-fill, RUN = serving requests)
//   dmem_lanes()   : number of byte lanes in a data word of a given width
// -----------------------------------------------------------------------------
package mem_sys_pkg;

   localparam logic [31:0] DMEM_BASE_ADDR = 32'h1001_0000;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } dmem_state_e;

   function automatic int dmem_lanes(input int data_width);
      return data_width / 32'sd8;
   endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl_if
// Request/response bus of the data memory.
//   request  : req_valid_i, req_ready_o, req_write_i, req_addr_i, req_wdata_i,
//              req_be_i (one strobe per byte lane)
//   response : rsp_valid_o (one-cycle pulse), rsp_rdata_o, rsp_err_o
//   status   : init_done_o (zero-fill complete)
// modport master : the requester; modport slave : the memory.
// -----------------------------------------------------------------------------
interface data_mem_ctrl_if
   import mem_sys_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);

   localparam int BE_W = dmem_lanes(DATA_WIDTH);

   logic                  req_valid_i;
   logic                  req_ready_o;
   logic                  req_write_i;
   logic [ADDR_WIDTH-1:0] req_addr_i;
   logic [DATA_WIDTH-1:0] req_wdata_i;
   logic [BE_W-1:0]       req_be_i;
   logic                  rsp_valid_o;
   logic [DATA_WIDTH-1:0] rsp_rdata_o;
   logic                  rsp_err_o;
   logic                  init_done_o;

   modport master (
      output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_be_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, init_done_o
   );

   modport slave (
      input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_be_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, init_done_o
   );

endinterface

// File: rtl/data_mem_ctrl_decode.sv
// -----------------------------------------------------------------------------
// dmem_decode
// Combinational address decode for the data memory window.
//   addr     : byte address of the request
//   in_range : address lies in [BASE_ADDR, BASE_ADDR + 4*DEPTH)
//   aligned  : address is word aligned
//   index    : word index inside the window (meaningful only when in_range)
// -----------------------------------------------------------------------------
module dmem_decode
   import mem_sys_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DEPTH      = 32,
   parameter int                    IDX_W      = 5,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = DMEM_BASE_ADDR
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic                  in_range,
   output logic                  aligned,
   output logic [IDX_W-1:0]      index
);

   // Window size in bytes, one bit wider so it cannot wrap for any DEPTH.
   localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(4 * DEPTH);

   logic [ADDR_WIDTH-1:0] off_s;

   // Offset from the window base; the >= test rejects addresses below the
   // base whose wrapped offset would otherwise look small.
   always_comb begin
      off_s    = addr - BASE_ADDR;
      in_range = (addr >= BASE_ADDR) && ({1'b0, off_s} < SPAN);
      aligned  = (addr[1:0] == 2'b00);
      index    = off_s[IDX_W+1:2];
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
// Single-port data memory mapping DEPTH words at byte address BASE_ADDR.
// After every reset the storage is zero-filled one word per cycle (INIT);
// afterwards one read or write per cycle is accepted and answered with a
// registered response on the following cycle (RUN).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : data_mem_ctrl_if.slave (request, response and init_done_o)
// Build option: DATA_MEM_BYTE_STROBE_EN
//   defined   -> writes update only lanes whose req_be_i bit is set
//   undefined -> req_be_i is ignored and writes update the full word
// -----------------------------------------------------------------------------
module data_mem_ctrl
   import mem_sys_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(DMEM_BASE_ADDR)
) (
   input  logic            clk,
   input  logic            rst_n,
   data_mem_ctrl_if.slave  bus
);

   localparam int             LANES    = dmem_lanes(DATA_WIDTH);
   localparam int             IDX_W    = $clog2(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   dmem_state_e           state_r;
   logic [IDX_W-1:0]      fill_cnt_r;
   logic                  ready_r;
   logic                  init_done_r;
   logic                  rsp_valid_r;
   logic                  rsp_err_r;
   logic [DATA_WIDTH-1:0] rsp_rdata_r;

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];

   logic                  in_range_s;
   logic                  aligned_s;
   logic [IDX_W-1:0]      index_s;
   logic                  accept_s;
   logic                  req_ok_s;
   logic [LANES-1:0]      wr_be_s;
   logic [DATA_WIDTH-1:0] rd_word_s;
   logic                  mem_we_s;
   logic [IDX_W-1:0]      mem_widx_s;
   logic [DATA_WIDTH-1:0] mem_wdata_s;
   logic [LANES-1:0]      mem_wbe_s;

   dmem_decode #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH),
      .IDX_W      (IDX_W),
      .BASE_ADDR  (BASE_ADDR)
   ) u_decode (
      .addr     (bus.req_addr_i),
      .in_range (in_range_s),
      .aligned  (aligned_s),
      .index    (index_s)
   );

`ifdef DATA_MEM_BYTE_STROBE_EN
   assign wr_be_s = bus.req_be_i;
`else
   // Strobes are not used in this build; the port stays for a common interface.
   logic unused_be_s;
   assign unused_be_s = ^bus.req_be_i;
   assign wr_be_s     = {LANES{1'b1}};
`endif

   // ready_r is high exactly in RUN, so it doubles as the accept qualifier.
   assign accept_s  = bus.req_valid_i && ready_r;
   assign req_ok_s  = in_range_s && aligned_s;
   assign rd_word_s = mem_r[index_s];

   // Single write port: zero-fill in INIT, checked request writes in RUN.
   always_comb begin
      mem_we_s    = 1'b0;
      mem_widx_s  = fill_cnt_r;
      mem_wdata_s = '0;
      mem_wbe_s   = {LANES{1'b1}};
      case (state_r)
         INIT: begin
            mem_we_s = 1'b1;
         end
         RUN: begin
            if (accept_s && bus.req_write_i && req_ok_s) begin
               mem_we_s    = 1'b1;
               mem_widx_s  = index_s;
               mem_wdata_s = bus.req_wdata_i;
               mem_wbe_s   = wr_be_s;
            end else begin
               mem_we_s    = 1'b0;
            end
         end
         default: begin
            mem_we_s = 1'b0;
         end
      endcase
   end

   // Storage array with per-lane write enables; contents are defined by the
   // zero-fill, so it carries no reset.
   always_ff @(posedge clk) begin
      for (int k = 0; k < LANES; k++) begin
         if (mem_we_s && mem_wbe_s[k]) begin
            mem_r[mem_widx_s][8*k +: 8] <= mem_wdata_s[8*k +: 8];
         end
      end
   end

   // Controller FSM with registered ready/done flags and response register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= INIT;
         fill_cnt_r  <= '0;
         ready_r     <= 1'b0;
         init_done_r <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
         rsp_rdata_r <= '0;
      end else begin
         case (state_r)
            INIT: begin
               rsp_valid_r <= 1'b0;
               rsp_err_r   <= 1'b0;
               rsp_rdata_r <= '0;
               if (fill_cnt_r == LAST_IDX) begin
                  state_r     <= RUN;
                  fill_cnt_r  <= '0;
                  ready_r     <= 1'b1;
                  init_done_r <= 1'b1;
               end else begin
                  fill_cnt_r  <= fill_cnt_r + IDX_W'(1);
               end
            end
            RUN: begin
               rsp_valid_r <= accept_s;
               rsp_err_r   <= accept_s && !req_ok_s;
               if (accept_s && !bus.req_write_i && req_ok_s) begin
                  rsp_rdata_r <= rd_word_s;
               end else begin
                  rsp_rdata_r <= '0;
               end
            end
            default: begin
               state_r     <= INIT;
               fill_cnt_r  <= '0;
               ready_r     <= 1'b0;
               init_done_r <= 1'b0;
               rsp_valid_r <= 1'b0;
               rsp_err_r   <= 1'b0;
               rsp_rdata_r <= '0;
            end
         endcase
      end
   end

   assign bus.req_ready_o = ready_r;
   assign bus.init_done_o = init_done_r;
   assign bus.rsp_valid_o = rsp_valid_r;
   assign bus.rsp_err_o   = rsp_err_r;
   assign bus.rsp_rdata_o = rsp_rdata_r;

endmodule
